systolic_feeder: RTL and testbench

//  Transmit side of the PE array operand interface. Accepts one A column-vector and one B row-vector
//  per beat over a valid/ready stream, skews lane i by i cycles and drives the west (A) and north (B)

---
 rtl/systolic_feeder_if.sv | 17 +
 rtl/systolic_feeder.sv | 152 +++++++++++++++
 tb/tb_systolic_feeder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - tile-control and operand stream bundle into systolic_feeder
interface systolic_feeder_if #(
    parameter int W     = 16,
    parameter int N     = 4,
    parameter int LEN_W = 8
) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic             mode;
    logic             valid;
    logic             ready;
    logic [N*W-1:0]   a;
    logic [N*W-1:0]   b;

    modport master (output start, len, mode, valid, a, b, input ready);
    modport slave  (input start, len, mode, valid, a, b, output ready);
endinterface

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skewing operand feeder and control sequencer for an N x N PE array
module systolic_feeder #(
    parameter int W     = 16,
    parameter int N     = 4,
    parameter int LEN_W = 8,
    parameter int DRAIN = 2*N+1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    systolic_feeder_if.slave   feed_if,
    output logic [N*W-1:0]     o_A,
    output logic [N*W-1:0]     o_B,
    output logic               o_sync,
    output logic               o_en,
    output logic               o_mode,
    output logic               o_busy,
    output logic               o_done
);
    localparam int FLUSH_W = $clog2(DRAIN+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_FEED,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_cnt_q;
    logic [FLUSH_W-1:0] flush_cnt_q;
    logic               ready_q;
    logic               sync_q;
    logic               en_q;
    logic               mode_q;
    logic               busy_q;
    logic               done_q;

    logic               xfer;
    logic [N*W-1:0]     a_d;
    logic [N*W-1:0]     b_d;

    // ready is only ever high in FEED, so a transfer can only happen there;
    // every other cycle pushes a zero slot into the skew lines
    assign xfer = feed_if.valid & ready_q;
    assign a_d  = xfer ? feed_if.a : '0;
    assign b_d  = xfer ? feed_if.b : '0;

    // lane k is a k+1 deep shift line; all lanes load at the same logical slot
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [W-1:0] a_line_q [k+1];
        logic [W-1:0] b_line_q [k+1];

        // shift line for lane k: stage 0 takes the slot, later stages ripple
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                for (int s = 0; s <= k; s++) begin
                    a_line_q[s] <= '0;
                    b_line_q[s] <= '0;
                end
            end else begin
                a_line_q[0] <= a_d[k*W +: W];
                b_line_q[0] <= b_d[k*W +: W];
                for (int s = 1; s <= k; s++) begin
                    a_line_q[s] <= a_line_q[s-1];
                    b_line_q[s] <= b_line_q[s-1];
                end
            end
        end

        assign o_A[k*W +: W] = a_line_q[k];
        assign o_B[k*W +: W] = b_line_q[k];
    end

    // tile sequencer; every array control is registered and set on the
    // transition into the state it belongs to
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            ready_q     <= 1'b0;
            sync_q      <= 1'b0;
            en_q        <= 1'b0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (feed_if.start) begin
                        len_q      <= feed_if.len;
                        mode_q     <= feed_if.mode;
                        beat_cnt_q <= '0;
                        sync_q     <= 1'b1;
                        en_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    sync_q <= 1'b0;
                    if (len_q == '0) begin
                        flush_cnt_q <= '0;
                        ready_q     <= 1'b0;
                        state_q     <= S_FLUSH;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                        // beat_cnt never passes len, so it cannot wrap even at len = 2^LEN_W-1
                        if (beat_cnt_q == len_q - LEN_W'(1)) begin
                            ready_q     <= 1'b0;
                            flush_cnt_q <= '0;
                            state_q     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q == FLUSH_W'(DRAIN-1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign feed_if.ready = ready_q;
    assign o_sync        = sync_q;
    assign o_en          = en_q;
    assign o_mode        = mode_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder with a matrix-product reference
module tb_systolic_feeder;
    localparam int W     = 16;
    localparam int N     = 4;
    localparam int LEN_W = 8;
    localparam int DRAIN = 2*N+1;
    localparam int HMAX  = 4096;
    localparam int BIG   = 1 << 30;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_feeder_if #(.W(W), .N(N), .LEN_W(LEN_W)) fif ();

    logic [N*W-1:0] o_A, o_B;
    logic o_sync, o_en, o_mode, o_busy, o_done;

    systolic_feeder #(.W(W), .N(N), .LEN_W(LEN_W), .DRAIN(DRAIN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .feed_if (fif),
        .o_A     (o_A),
        .o_B     (o_B),
        .o_sync  (o_sync),
        .o_en    (o_en),
        .o_mode  (o_mode),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int             c;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
    } slot_t;

    slot_t  slot_q [$];
    longint done_q [$];

    bit     m_busy = 0;
    int     m_len = 0, m_cnt = 0, exp_sync = BIG, exp_done = BIG;
    bit     m_mode = 0;
    longint m_c [N*N];

    logic [N*W-1:0] ba [256];
    logic [N*W-1:0] bb [256];
    logic [N*W-1:0] ha [HMAX];
    logic [N*W-1:0] hb [HMAX];
    longint mc [N][N];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // stimulus-side model: records every input slot and the tile timeline
    always @(negedge clk) begin : pusher
        bit    act;
        bit    xfer;
        slot_t s;
        if (!rst_n) begin
            slot_q.delete();
            done_q.delete();
            m_busy   = 0;
            exp_sync = BIG;
            exp_done = BIG;
        end else begin
            act = m_busy && cyc >= exp_sync && cyc <= exp_done;
            chk_bit("en", o_en, act);
            chk_bit("busy", o_busy, act);
            chk_bit("sync", o_sync, m_busy && cyc == exp_sync);
            chk_bit("done", o_done, m_busy && cyc == exp_done);
            chk_bit("ready", fif.ready, m_busy && cyc > exp_sync && m_cnt < m_len);
            if (act) chk_bit("mode", o_mode, m_mode);
            xfer = fif.valid && fif.ready;
            s.c = cyc;
            s.a = xfer ? fif.a : '0;
            s.b = xfer ? fif.b : '0;
            slot_q.push_back(s);
            if (xfer) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        m_c[r*N+c] += longint'(s.a[r*W +: W]) * longint'(s.b[c*W +: W]);
                m_cnt++;
                if (m_cnt == m_len) begin
                    exp_done = cyc + DRAIN + 1;
                    for (int i = 0; i < N*N; i++) done_q.push_back(m_c[i]);
                end
            end
            if (m_busy && cyc == exp_done) begin
                m_busy = 0;
            end else if (!m_busy && fif.start) begin
                m_busy   = 1;
                m_len    = int'(fif.len);
                m_mode   = fif.mode;
                m_cnt    = 0;
                exp_sync = cyc + 1;
                for (int i = 0; i < N*N; i++) m_c[i] = 0;
                if (m_len == 0) begin
                    exp_done = cyc + DRAIN + 2;
                    for (int i = 0; i < N*N; i++) done_q.push_back(0);
                end else begin
                    exp_done = BIG;
                end
            end
        end
    end

    // output monitor: de-skews lanes back into slots and runs a PE array model
    always @(posedge clk) begin : monitor
        slot_t          s;
        logic [N*W-1:0] ga, gb;
        int             ia, ib;
        #2;
        ha[cyc % HMAX] = o_A;
        hb[cyc % HMAX] = o_B;
        if (o_sync)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) mc[r][c] = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (cyc - c >= 0 && cyc - r >= 0) begin
                    ia = (cyc - c) % HMAX;
                    ib = (cyc - r) % HMAX;
                    mc[r][c] += longint'(ha[ia][r*W +: W]) * longint'(hb[ib][c*W +: W]);
                end
        while (slot_q.size() > 0 && slot_q[0].c < cyc - N) begin
            s = slot_q.pop_front();
            chk_val("slot_lost", 64'(s.c), 64'(cyc - N));
        end
        if (slot_q.size() > 0 && slot_q[0].c == cyc - N) begin
            s = slot_q.pop_front();
            for (int r = 0; r < N; r++) begin
                ga[r*W +: W] = ha[(cyc - N + 1 + r) % HMAX][r*W +: W];
                gb[r*W +: W] = hb[(cyc - N + 1 + r) % HMAX][r*W +: W];
            end
            chk_val("skew_A", ga, s.a);
            chk_val("skew_B", gb, s.b);
        end
        if (o_done) begin
            if (done_q.size() < N*N) begin
                chk_val("done_unexpected", 64'(done_q.size()), 64'(N*N));
            end else begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        chk_val("result_C", mc[r][c], done_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk_val({tag, "_oA"}, o_A, '0);
        chk_val({tag, "_oB"}, o_B, '0);
        chk_val({tag, "_ctl"}, 64'({o_sync, o_en, o_mode, o_busy, o_done, fif.ready}), '0);
    endtask

    task automatic run_tile(input int len, input bit mode, input int gap_beat, input int gap_len,
                            input bit rnd_gaps, input bit poke, input int abort_after);
        int k, gaps, guard;
        bit hold, x;
        fif.start = 1'b1;
        fif.len   = LEN_W'(len);
        fif.mode  = mode;
        @(posedge clk); #1;
        fif.start = 1'b0;
        fif.len   = LEN_W'($urandom);
        fif.mode  = 1'($urandom);
        k = 0; gaps = 0; guard = 0;
        while (k < len && guard < 600) begin
            if (abort_after >= 0 && k == abort_after) break;
            hold = (k == gap_beat && gaps < gap_len) || (rnd_gaps && $urandom_range(0, 3) == 0);
            fif.valid = !hold;
            fif.a     = hold ? {$urandom, $urandom} : ba[k];
            fif.b     = hold ? {$urandom, $urandom} : bb[k];
            fif.start = poke && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            x = fif.valid && fif.ready;
            @(posedge clk); #1;
            if (hold && k == gap_beat) gaps++;
            if (x) k++;
            guard++;
        end
        fif.valid = 1'b0;
        fif.start = 1'b0;
        if (abort_after >= 0) return;
        if (k < len) chk_val("beat_timeout", 64'(k), 64'(len));
        guard = 0;
        while (m_busy && guard < 200) begin
            fif.start = poke;
            @(posedge clk); #1;
            guard++;
        end
        fif.start = 1'b0;
        if (m_busy) chk_bit("done_timeout", 1'b0, 1'b1);
        idle(2);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        rst_n     = 1'b0;
        fif.start = 1'b0;
        fif.len   = '0;
        fif.mode  = 1'b0;
        fif.valid = 1'b0;
        fif.a     = '0;
        fif.b     = '0;
        idle(3);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // skew: single beat, lanes 1..4 / 5..8
        ba[0] = {16'd4, 16'd3, 16'd2, 16'd1};
        bb[0] = {16'd8, 16'd7, 16'd6, 16'd5};
        run_tile(1, 1'b0, -1, 0, 1'b0, 1'b0, -1);

        // identity A against counting B
        for (int k = 0; k < N; k++)
            for (int r = 0; r < N; r++) begin
                ba[k][r*W +: W] = (r == k) ? 16'd1 : 16'd0;
                bb[k][r*W +: W] = 16'(N*k + r + 1);
            end
        run_tile(4, 1'b1, -1, 0, 1'b0, 1'b0, -1);

        // same tile with a 3-cycle valid gap between beats 2 and 3
        run_tile(4, 1'b1, 2, 3, 1'b0, 1'b0, -1);

        // empty tile
        run_tile(0, 1'b0, -1, 0, 1'b0, 1'b0, -1);

        // random data, start poked while busy
        for (int k = 0; k < 256; k++) begin
            ba[k] = {$urandom, $urandom};
            bb[k] = {$urandom, $urandom};
        end
        run_tile(5, 1'b1, -1, 0, 1'b1, 1'b1, -1);

        for (int t = 0; t < 10; t++)
            run_tile($urandom_range(1, 12), 1'($urandom), -1, 0, 1'b1, 1'($urandom), -1);

        // longest tile the length field allows
        run_tile(255, 1'b0, -1, 0, 1'b0, 1'b0, -1);

        // reset in the middle of FEED
        run_tile(6, 1'b1, -1, 0, 1'b0, 1'b0, 2);
        rst_n = 1'b0;
        idle(3);
        check_zero_outputs("midreset_hold");
        rst_n = 1'b1;
        idle(1);
        check_zero_outputs("midreset_after");
        idle(20);

        run_tile(3, 1'b0, -1, 0, 1'b1, 1'b0, -1);
        idle(N + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
